// File: rtl/ttt_turn_ctrl.sv
// Turn sequencer and move arbiter for the tic-tac-toe board: serves one player's req/ack at a time,
// rejects illegal moves, writes legal ones to the board, and ends the game on win, draw or timeout.
module ttt_turn_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p0_req,
    input  logic [1:0] p0_x,
    input  logic [1:0] p0_y,
    output logic       p0_ack,
    input  logic       p1_req,
    input  logic [1:0] p1_x,
    input  logic [1:0] p1_y,
    output logic       p1_ack,
    output logic       reject,
    output logic       brd_en,
    output logic [1:0] brd_x,
    output logic [1:0] brd_y,
    output logic [1:0] brd_player,
    output logic       brd_clr,
    input  logic       brd_winner,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] result,
    output logic       forfeit
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, TURN, ISSUE, CHECK, DONE} state_t;

    state_t          state_q;
    logic            turn_q, starter_q;
    logic            p0_ack_q, p1_ack_q, reject_q, brd_en_q, brd_clr_q;
    logic [1:0]      brd_x_q, brd_y_q;
    logic            game_over_q, forfeit_q;
    logic [1:0]      result_q;
    logic [8:0]      map_q;
    logic [3:0]      cnt_q;
    logic [TW-1:0]   tcnt_q;

    logic            cur_req, cur_ack, cur_legal, take, bad;
    logic [1:0]      cur_x, cur_y;
    logic [3:0]      cur_idx, lat_idx;

    // A request is only eligible while its own ack is low, so a held req is consumed once.
    always_comb begin
        cur_req   = turn_q ? p1_req : p0_req;
        cur_ack   = turn_q ? p1_ack_q : p0_ack_q;
        cur_x     = turn_q ? p1_x : p0_x;
        cur_y     = turn_q ? p1_y : p0_y;
        cur_idx   = ({2'b00, cur_x} * 4'd3) + {2'b00, cur_y};
        lat_idx   = ({2'b00, brd_x_q} * 4'd3) + {2'b00, brd_y_q};
        cur_legal = 1'b0;
        if (cur_x != 2'd3 && cur_y != 2'd3 && cur_idx < 4'd9)
            cur_legal = !map_q[cur_idx];
        take = (state_q == TURN) && cur_req && !cur_ack && cur_legal;
        bad  = (state_q == TURN) && cur_req && !cur_ack && !cur_legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            turn_q      <= 1'b0;
            starter_q   <= 1'b0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            reject_q    <= 1'b0;
            brd_en_q    <= 1'b0;
            brd_clr_q   <= 1'b0;
            brd_x_q     <= 2'd0;
            brd_y_q     <= 2'd0;
            game_over_q <= 1'b0;
            result_q    <= 2'b00;
            forfeit_q   <= 1'b0;
            map_q       <= 9'd0;
            cnt_q       <= 4'd0;
            tcnt_q      <= '0;
        end else begin
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            reject_q  <= 1'b0;
            brd_en_q  <= 1'b0;
            brd_clr_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= CLEAR;
                        brd_clr_q   <= 1'b1;
                        turn_q      <= starter_q;
                        starter_q   <= ~starter_q;
                        game_over_q <= 1'b0;
                        result_q    <= 2'b00;
                        forfeit_q   <= 1'b0;
                    end
                end
                CLEAR: begin
                    map_q   <= 9'd0;
                    cnt_q   <= 4'd0;
                    tcnt_q  <= '0;
                    state_q <= TURN;
                end
                TURN: begin
                    if (take) begin
                        state_q  <= ISSUE;
                        brd_en_q <= 1'b1;
                        brd_x_q  <= cur_x;
                        brd_y_q  <= cur_y;
                        if (turn_q) p1_ack_q <= 1'b1;
                        else        p0_ack_q <= 1'b1;
                    end else begin
                        if (bad) begin
                            reject_q <= 1'b1;
                            if (turn_q) p1_ack_q <= 1'b1;
                            else        p0_ack_q <= 1'b1;
                        end
                        if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            state_q     <= DONE;
                            game_over_q <= 1'b1;
                            forfeit_q   <= 1'b1;
                            result_q    <= turn_q ? 2'b01 : 2'b10;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end
                ISSUE: begin
                    map_q[lat_idx] <= 1'b1;
                    cnt_q          <= cnt_q + 4'd1;
                    state_q        <= CHECK;
                end
                CHECK: begin
                    // A line completed by the ninth move is a win, so the winner flag outranks the draw count.
                    if (brd_winner) begin
                        state_q     <= DONE;
                        game_over_q <= 1'b1;
                        result_q    <= turn_q ? 2'b10 : 2'b01;
                    end else if (cnt_q == 4'd9) begin
                        state_q     <= DONE;
                        game_over_q <= 1'b1;
                        result_q    <= 2'b11;
                    end else begin
                        turn_q  <= ~turn_q;
                        tcnt_q  <= '0;
                        state_q <= TURN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;
    assign reject     = reject_q;
    assign brd_en     = brd_en_q;
    assign brd_x      = brd_x_q;
    assign brd_y      = brd_y_q;
    assign brd_player = {1'b0, turn_q};
    assign brd_clr    = brd_clr_q;
    assign turn       = turn_q;
    assign game_over  = game_over_q;
    assign result     = result_q;
    assign forfeit    = forfeit_q;
endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with TIMEOUT_CYCLES=8: win, illegal moves, timeout, draw,
// starter toggle, simultaneous requests and reset during CHECK.
module tb_ttt_turn_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       p0_req = 1'b0, p1_req = 1'b0, brd_winner = 1'b0;
    logic [1:0] p0_x = 2'd0, p0_y = 2'd0, p1_x = 2'd0, p1_y = 2'd0;
    logic       p0_ack, p1_ack, reject, brd_en, brd_clr, turn, game_over, forfeit;
    logic [1:0] brd_x, brd_y, brd_player, result;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    logic [1:0] pl_log[$];

    always #5 clk = ~clk;

    ttt_turn_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p0_req(p0_req), .p0_x(p0_x), .p0_y(p0_y), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y), .p1_ack(p1_ack),
        .reject(reject), .brd_en(brd_en), .brd_x(brd_x), .brd_y(brd_y),
        .brd_player(brd_player), .brd_clr(brd_clr), .brd_winner(brd_winner),
        .turn(turn), .game_over(game_over), .result(result), .forfeit(forfeit)
    );

    always @(negedge clk) begin
        if (brd_en === 1'b1) begin
            en_cnt = en_cnt + 1;
            pl_log.push_back(brd_player);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p0_req = 1'b0; p1_req = 1'b0; start = 1'b0; brd_winner = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Leaves the bench one cycle into TURN; clr reports the strobe seen in CLEAR.
    task automatic do_start(output logic clr);
        start = 1'b1;
        tick();
        clr = brd_clr;
        start = 1'b0;
        tick();
    endtask

    // Drives one request until acked; a legal move is then walked through ISSUE and CHECK.
    task automatic play(input logic p, input logic [1:0] x, input logic [1:0] y, input logic win,
                        output logic acked, output logic rej);
        acked = 1'b0;
        rej   = 1'b0;
        if (p) begin p1_req = 1'b1; p1_x = x; p1_y = y; end
        else   begin p0_req = 1'b1; p0_x = x; p0_y = y; end
        for (int i = 0; i < 20 && !acked; i++) begin
            tick();
            if ((p ? p1_ack : p0_ack) === 1'b1) begin
                acked = 1'b1;
                rej   = reject;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        if (!acked) begin
            checks++; errors++;
            $display("FAIL play_ack_wait: player %0d got no ack within 20 cycles", p);
        end else if (!rej) begin
            tick();
            brd_winner = win;
            tick();
            brd_winner = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({game_over, forfeit, brd_en, brd_clr, p0_ack, p1_ack, reject, turn} !== 8'd0) begin
            errors++; $display("FAIL reset_flags: got %b, required 00000000",
                {game_over, forfeit, brd_en, brd_clr, p0_ack, p1_ack, reject, turn});
        end
        checks++;
        if (result !== 2'b00) begin errors++; $display("FAIL reset_result: got %b, required 00", result); end
        checks++;
        if ({brd_x, brd_y, brd_player} !== 6'd0) begin
            errors++; $display("FAIL reset_brd: got %b, required 000000", {brd_x, brd_y, brd_player});
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_win();
        logic clr, a, r;
        int base;
        logic [9:0] seq;
        do_reset();
        base = en_cnt;
        do_start(clr);
        checks++;
        if (clr !== 1'b1) begin errors++; $display("FAIL win_clr: got %b, required 1", clr); end
        checks++;
        if (turn !== 1'b0) begin errors++; $display("FAIL win_first_turn: got %b, required 0", turn); end
        play(1'b0, 2'd0, 2'd0, 1'b0, a, r);
        checks++;
        if (turn !== 1'b1) begin errors++; $display("FAIL win_turn_toggle: got %b, required 1", turn); end
        brd_winner = 1'b1;
        tick();
        brd_winner = 1'b0;
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL win_flag_outside_check: got %b, required 0", game_over); end
        play(1'b1, 2'd1, 2'd1, 1'b0, a, r);
        play(1'b0, 2'd0, 2'd1, 1'b0, a, r);
        play(1'b1, 2'd2, 2'd2, 1'b0, a, r);
        play(1'b0, 2'd0, 2'd2, 1'b1, a, r);
        checks++;
        if ({game_over, result, forfeit} !== 4'b1010) begin
            errors++; $display("FAIL win_end: got go/res/ff %b, required 1010", {game_over, result, forfeit});
        end
        checks++;
        if (en_cnt - base !== 5) begin errors++; $display("FAIL win_en_count: got %0d, required 5", en_cnt - base); end
        seq = '1;
        if (en_cnt - base >= 5)
            for (int i = 0; i < 5; i++) seq[2*i +: 2] = pl_log[base + i];
        checks++;
        if (seq !== 10'b00_01_00_01_00) begin errors++; $display("FAIL win_player_seq: got %b, required 0001000100", seq); end
        checks++;
        if ({brd_x, brd_y} !== 4'b0010) begin errors++; $display("FAIL win_last_xy: got %b, required 0010", {brd_x, brd_y}); end
    endtask

    task automatic test_illegal();
        logic clr, a, r;
        int base;
        do_reset();
        do_start(clr);
        play(1'b0, 2'd1, 2'd1, 1'b0, a, r);
        base = en_cnt;
        play(1'b1, 2'd1, 2'd1, 1'b0, a, r);
        checks++;
        if ({a, r} !== 2'b11) begin errors++; $display("FAIL ill_occupied: got ack/rej %b, required 11", {a, r}); end
        checks++;
        if (turn !== 1'b1) begin errors++; $display("FAIL ill_turn: got %b, required 1", turn); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (brd_clr !== 1'b0) begin errors++; $display("FAIL ill_start_ignored: got %b, required 0", brd_clr); end
        play(1'b1, 2'd3, 2'd0, 1'b0, a, r);
        checks++;
        if ({a, r} !== 2'b11) begin errors++; $display("FAIL ill_range: got ack/rej %b, required 11", {a, r}); end
        checks++;
        if (en_cnt - base !== 0) begin errors++; $display("FAIL ill_no_write: got %0d, required 0", en_cnt - base); end
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL ill_game_over: got %b, required 0", game_over); end
    endtask

    task automatic test_timeout();
        logic clr, a, r;
        int first;
        do_reset();
        do_start(clr);
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (game_over === 1'b1 && first == 0) first = i;
        end
        // 8th TURN cycle expires; DONE shows in the 9th, i.e. 8 edges after TURN entry.
        checks++;
        if (first !== 8) begin errors++; $display("FAIL to_latency: got %0d edges, required 8", first); end
        checks++;
        if ({result, forfeit} !== 3'b101) begin errors++; $display("FAIL to_result: got %b, required 101", {result, forfeit}); end
        do_reset();
        do_start(clr);
        repeat (7) tick();
        play(1'b0, 2'd2, 2'd2, 1'b0, a, r);
        checks++;
        if ({a, r} !== 2'b10) begin errors++; $display("FAIL to_edge_move: got ack/rej %b, required 10", {a, r}); end
        checks++;
        if ({game_over, forfeit, turn} !== 3'b001) begin
            errors++; $display("FAIL to_edge_state: got go/ff/turn %b, required 001", {game_over, forfeit, turn});
        end
    endtask

    task automatic test_draw();
        logic clr, a, r;
        int base;
        do_reset();
        do_start(clr);
        base = en_cnt;
        for (int i = 0; i < 9; i++) begin
            play(1'(i % 2), 2'(i / 3), 2'(i % 3), 1'b0, a, r);
            if (i == 7) begin
                checks++;
                if (game_over !== 1'b0) begin errors++; $display("FAIL draw_early_end: got %b, required 0", game_over); end
            end
        end
        checks++;
        if ({game_over, result, forfeit} !== 4'b1110) begin
            errors++; $display("FAIL draw_end: got go/res/ff %b, required 1110", {game_over, result, forfeit});
        end
        checks++;
        if (en_cnt - base !== 9) begin errors++; $display("FAIL draw_en_count: got %0d, required 9", en_cnt - base); end
        do_start(clr);
        checks++;
        if ({clr, turn, game_over, result} !== 5'b11000) begin
            errors++; $display("FAIL draw_restart: got clr/turn/go/res %b, required 11000", {clr, turn, game_over, result});
        end
        for (int i = 0; i < 9; i++)
            play(1'((i + 1) % 2), 2'(i / 3), 2'(i % 3), (i == 8) ? 1'b1 : 1'b0, a, r);
        checks++;
        if ({game_over, result} !== 3'b110) begin
            errors++; $display("FAIL win_on_ninth: got go/res %b, required 110", {game_over, result});
        end
    endtask

    task automatic test_both_req();
        logic clr;
        int base;
        do_reset();
        do_start(clr);
        base = en_cnt;
        p0_req = 1'b1; p0_x = 2'd0; p0_y = 2'd0;
        p1_req = 1'b1; p1_x = 2'd2; p1_y = 2'd2;
        tick();
        checks++;
        if ({p0_ack, p1_ack} !== 2'b10) begin errors++; $display("FAIL both_acks: got p0/p1 %b, required 10", {p0_ack, p1_ack}); end
        checks++;
        if ({brd_x, brd_y, brd_player} !== 6'd0) begin
            errors++; $display("FAIL both_write: got %b, required 000000", {brd_x, brd_y, brd_player});
        end
        p1_req = 1'b0;
        repeat (6) tick();
        p0_req = 1'b0;
        checks++;
        if (en_cnt - base !== 1) begin errors++; $display("FAIL both_single_write: got %0d, required 1", en_cnt - base); end
        checks++;
        if ({turn, game_over} !== 2'b10) begin errors++; $display("FAIL both_turn: got %b, required 10", {turn, game_over}); end
    endtask

    task automatic test_reset_check();
        logic clr, a, r;
        do_reset();
        do_start(clr);
        play(1'b0, 2'd0, 2'd0, 1'b0, a, r);
        p1_req = 1'b1; p1_x = 2'd1; p1_y = 2'd0;
        tick();
        p1_req = 1'b0;
        tick();
        checks++;
        if (turn !== 1'b1) begin errors++; $display("FAIL rst_pre_turn: got %b, required 1", turn); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({game_over, result, turn, brd_en, forfeit} !== 6'd0) begin
            errors++; $display("FAIL rst_immediate: got %b, required 000000", {game_over, result, turn, brd_en, forfeit});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({brd_clr, brd_en} !== 2'b00) begin errors++; $display("FAIL rst_idle_quiet: got %b, required 00", {brd_clr, brd_en}); end
        do_start(clr);
        checks++;
        if ({clr, turn} !== 2'b10) begin errors++; $display("FAIL rst_restart: got clr/turn %b, required 10", {clr, turn}); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_illegal();
        test_timeout();
        test_draw();
        test_both_req();
        test_reset_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end
endmodule
